// File: rtl/gemm_pkg.sv
// Shared defaults and FSM state type for the GEMM output streaming slice.
package gemm_pkg;

  localparam int unsigned GEMM_DW    = 32;
  localparam int unsigned GEMM_DEPTH = 16;
  localparam int unsigned GEMM_MAXW  = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/gemm_fwft_fifo.sv
// First-word-fall-through result FIFO: the head word is visible on data_o
// the cycle after it is written into an empty FIFO.
module gemm_fwft_fifo
  import gemm_pkg::*;
#(
  parameter int unsigned DW    = GEMM_DW,
  parameter int unsigned DEPTH = GEMM_DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Occupancy counter, not pointer comparison, separates full from empty.
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/gemm_out_stream.sv
// Streams a fixed-size burst of compute-core results out over AXI-Stream,
// buffering through a FWFT FIFO and framing the burst with TLAST/done.
module gemm_out_stream
  import gemm_pkg::*;
#(
  parameter int unsigned DW    = GEMM_DW,
  parameter int unsigned DEPTH = GEMM_DEPTH,
  parameter int unsigned MAXW  = GEMM_MAXW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [6:0]      size,
  input  logic            res_valid,
  input  logic [DW-1:0]   res_data,
  output logic            res_ready,
  output logic            M_AXIS_TVALID,
  output logic [DW-1:0]   M_AXIS_TDATA,
  output logic [DW/8-1:0] M_AXIS_TSTRB,
  output logic            M_AXIS_TLAST,
  input  logic            M_AXIS_TREADY,
  output logic            busy,
  output logic            done
);

  state_e        state_q, state_d;
  logic [6:0]    size_q, size_d;
  logic [6:0]    in_cnt_q, in_cnt_d;
  logic [6:0]    out_cnt_q, out_cnt_d;
  logic          done_q, done_d;

  logic          fifo_full, fifo_empty;
  logic [DW-1:0] fifo_head;
  logic          push, pop, start_ok, hs_last;

  gemm_fwft_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (res_data),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sizes outside 1..MAXW are treated like size 0 and leave the block idle.
  assign start_ok = start & (state_q == IDLE) & (size != '0) & (32'(size) <= MAXW);

  assign res_ready     = (state_q == RUN) & ~fifo_full & (in_cnt_q < size_q);
  assign push          = res_valid & res_ready;
  assign M_AXIS_TVALID = ~fifo_empty;
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? fifo_head : '0;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = M_AXIS_TVALID & (out_cnt_q == size_q - 7'd1);
  assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;
  assign hs_last       = pop & M_AXIS_TLAST;
  assign busy          = (state_q == RUN);
  assign done          = done_q;

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = hs_last;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d   = RUN;
          size_d    = size;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      RUN: begin
        in_cnt_d  = in_cnt_q + {6'd0, push};
        out_cnt_d = out_cnt_q + {6'd0, pop};
        if (hs_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      size_q    <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
    end
  end

endmodule
